// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-triggered, single-level interrupt controller for the CP0 interface.
// Latches rising edges on irq_in as pending bits and qualifies them with CP0 status.
// The lowest-indexed eligible line is presented as a held request until it is
// acknowledged, then tracked as in service until eret.
module intr_ctrl #(
    parameter int         NIRQ       = 6,
    parameter logic [4:0] CAUSE_BASE = 5'd16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_in,
    input  logic [NIRQ-1:0] irq_clr,
    input  logic [31:0]     status,
    input  logic            intr_ack,
    input  logic            eret,
    output logic            intr,
    output logic [4:0]      cause,
    output logic [2:0]      irq_id,
    output logic [NIRQ-1:0] pending,
    output logic            in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t          state;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] edges;
    logic [NIRQ-1:0] eligible;
    logic            any_eligible;
    logic [2:0]      winner;
    logic            ack_take;

    // Status bits above the per-line enables have no meaning here.
    logic unused_status;
    assign unused_status = ^status[31:NIRQ+1];

    assign edges    = irq_in & ~irq_q;
    assign eligible = status[0] ? (pending & status[NIRQ:1]) : '0;
    // Only an ack that arrives while a request is outstanding retires a line.
    assign ack_take = (state == REQ) && intr_ack;

    // Priority encoder: scan downwards so the lowest eligible index is left last.
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner       = 3'(i);
                any_eligible = 1'b1;
            end
        end
    end

    // Previous-cycle copy of the raw lines for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_in;
        end
    end

    // Pending bits: a new edge beats a software clear, which beats an ack clear.
    generate
        for (genvar gi = 0; gi < NIRQ; gi++) begin : g_pending
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pending[gi] <= 1'b0;
                end else if (edges[gi]) begin
                    pending[gi] <= 1'b1;
                end else if (irq_clr[gi]) begin
                    pending[gi] <= 1'b0;
                end else if (ack_take && (irq_id == 3'(gi))) begin
                    pending[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Request/service FSM; intr and in_service are registered state decodes and
    // irq_id/cause are frozen from the moment a request is raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            intr       <= 1'b0;
            in_service <= 1'b0;
            irq_id     <= '0;
            cause      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        state  <= REQ;
                        intr   <= 1'b1;
                        irq_id <= winner;
                        cause  <= CAUSE_BASE + {2'b00, winner};
                    end
                end
                REQ: begin
                    if (intr_ack) begin
                        state      <= SVC;
                        intr       <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                SVC: begin
                    if (eret) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    intr       <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule
